// File: rtl/scarv_soc_pkg.sv
// Shared SoC constants: requester indices and the response-owner record
// carried from the accept cycle to the response cycle.
package scarv_soc_pkg;

  localparam int unsigned N_REQ     = 2;
  localparam logic        REQ_IFETCH = 1'b0;
  localparam logic        REQ_DATA   = 1'b1;

  localparam int unsigned RSP_IDX_W = 1;
  localparam int unsigned RSP_ERR_W = 1;

  // rd distinguishes reads from writes so write responses return zero data.
  typedef struct packed {
    logic                 vld;
    logic [RSP_IDX_W-1:0] idx;
    logic [RSP_ERR_W-1:0] err;
    logic                 rd;
  } rsp_owner_t;

endpackage

// File: rtl/scarv_soc_rr_arb2.sv
// Two-way round-robin grant. The pointer remembers the last granted index,
// so on a tie the other requester wins.
module scarv_soc_rr_arb2
  import scarv_soc_pkg::*;
(
  input  logic             clka,
  input  logic             rsta,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt
);

  logic ptr_q;

  always_comb begin
    gnt = '0;
    if (!rsta) begin
      if (req[0] && req[1]) begin
        gnt[0] = ptr_q;
        gnt[1] = !ptr_q;
      end else begin
        gnt = req;
      end
    end
  end

  // Reset value makes requester 0 the winner of the first tie.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      ptr_q <= REQ_DATA;
    end else if (gnt[0]) begin
      ptr_q <= REQ_IFETCH;
    end else if (gnt[1]) begin
      ptr_q <= REQ_DATA;
    end
  end

endmodule

// File: rtl/scarv_soc_bram_arbiter.sv
// Two-requester front end for a single-port BRAM: round-robin grant, window
// decode with error responses, and a one-cycle response path.
module scarv_soc_bram_arbiter
  import scarv_soc_pkg::*;
#(
  parameter  int unsigned DEPTH = 1024,
  parameter  logic [31:0] BASE  = 32'h0,
  localparam int unsigned LW    = $clog2(DEPTH)
) (
  input  logic          clka,
  input  logic          rsta,

  input  logic          r0_req,
  output logic          r0_gnt,
  input  logic          r0_wen,
  input  logic [3:0]    r0_strb,
  input  logic [31:0]   r0_addr,
  input  logic [31:0]   r0_wdata,
  output logic          r0_rsp,
  output logic          r0_err,
  output logic [31:0]   r0_rdata,

  input  logic          r1_req,
  output logic          r1_gnt,
  input  logic          r1_wen,
  input  logic [3:0]    r1_strb,
  input  logic [31:0]   r1_addr,
  input  logic [31:0]   r1_wdata,
  output logic          r1_rsp,
  output logic          r1_err,
  output logic [31:0]   r1_rdata,

  output logic          ena,
  output logic [3:0]    wea,
  output logic [LW-1:0] addra,
  output logic [31:0]   dina,
  input  logic [31:0]   douta
);

  function automatic logic in_window(input logic [31:0] off);
    return off < 32'(DEPTH);
  endfunction

  logic [N_REQ-1:0] req_p0;
  logic [N_REQ-1:0] gnt_p0;
  logic             acc_p0;
  logic             sel_p0;
  logic             wen_p0;
  logic [3:0]       strb_p0;
  logic [31:0]      addr_p0;
  logic [31:0]      wdata_p0;
  logic [31:0]      off_p0;
  logic             inr_p0;
  rsp_owner_t       rsp_p0;
  rsp_owner_t       rsp_p1;
  logic             hit0_p1;
  logic             hit1_p1;
  logic [31:0]      rdata_p1;

  // ---- stage p0: arbitration, request mux and BRAM drive ----
  assign req_p0 = {r1_req, r0_req};

  scarv_soc_rr_arb2 u_arb (
    .clka (clka),
    .rsta (rsta),
    .req  (req_p0),
    .gnt  (gnt_p0)
  );

  assign r0_gnt = gnt_p0[REQ_IFETCH];
  assign r1_gnt = gnt_p0[REQ_DATA];
  assign acc_p0 = |gnt_p0;
  assign sel_p0 = gnt_p0[REQ_DATA];

  always_comb begin
    wen_p0   = r0_wen;
    strb_p0  = r0_strb;
    addr_p0  = r0_addr;
    wdata_p0 = r0_wdata;
    if (sel_p0) begin
      wen_p0   = r1_wen;
      strb_p0  = r1_strb;
      addr_p0  = r1_addr;
      wdata_p0 = r1_wdata;
    end
  end

  // Subtracting BASE first lets addresses below the window wrap high and
  // fall out of range with a single compare.
  assign off_p0 = addr_p0 - BASE;
  assign inr_p0 = in_window(off_p0);

  assign ena   = acc_p0 && inr_p0;
  assign wea   = (ena && wen_p0) ? strb_p0 : 4'b0000;
  assign addra = off_p0[LW-1:0];
  assign dina  = wdata_p0;

  always_comb begin
    rsp_p0     = '0;
    rsp_p0.vld = acc_p0;
    rsp_p0.idx = sel_p0;
    rsp_p0.err = !inr_p0;
    rsp_p0.rd  = !wen_p0;
  end

  // ---- stage p1: response owner, aligned with registered BRAM output ----
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      rsp_p1.vld <= 1'b0;
    end else begin
      rsp_p1 <= rsp_p0;
    end
  end

  assign hit0_p1  = rsp_p1.vld && (rsp_p1.idx == REQ_IFETCH);
  assign hit1_p1  = rsp_p1.vld && (rsp_p1.idx == REQ_DATA);
  assign rdata_p1 = (rsp_p1.rd && !rsp_p1.err) ? douta : 32'h0;

  assign r0_rsp   = hit0_p1;
  assign r0_err   = hit0_p1 && rsp_p1.err[0];
  assign r0_rdata = hit0_p1 ? rdata_p1 : 32'h0;

  assign r1_rsp   = hit1_p1;
  assign r1_err   = hit1_p1 && rsp_p1.err[0];
  assign r1_rdata = hit1_p1 ? rdata_p1 : 32'h0;

endmodule
